regmem_unit: RTL and testbench
==============================

// Module: regmem_unit
// PURPOSE
//  Clocked, parametrised successor of the processor's combinational register/data-memory block.
//  Holds an NREG x DW register file and a DEPTH x DW data memory with a synchronous read port.
//  Executes one command at a time over a valid/ready pair: load-immediate, reg->reg move,
//  data->reg load and reg->data store. Returns results over a valid/ready response channel.
//  Sits between the decode stage and writeback in the 8-bit Harvard datapath.
// PARAMETERS
//  DW     8   data width of registers, memory words and immediates
//  NREG   32  register count; must be a power of 2; RAW = $clog2(NREG)
//  DEPTH  32  data-memory words; must be a power of 2; MAW = $clog2(DEPTH)
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    unit accepts a command this cycle
//  cmd_op     in   2    00 LDI, 01 MOVE, 10 LOAD (mem->reg), 11 STORE (reg->mem)
//  cmd_rdst1  in   RAW  destination register (all ops except STORE)
//  cmd_rdst2  in   RAW  second destination register (LDI only)
//  cmd_rsrc1  in   RAW  source register (MOVE/STORE); readback register 1 (LDI)
//  cmd_rsrc2  in   RAW  readback register 2 (LDI)
//  cmd_imm1   in   DW   immediate for rdst1 (LDI)
//  cmd_imm2   in   DW   immediate for rdst2 (LDI)
//  cmd_addr   in   MAW  data-memory address (LOAD/STORE)
//  rsp_valid  out  1    response present
//  rsp_ready  in   1    consumer takes the response
//  rsp_r1     out  DW   primary result
//  rsp_r2     out  DW   secondary result (LDI only; 0 for all other ops)
//  busy       out  1    high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; rsp_valid=0; rsp_r1=rsp_r2=0; busy=0; all registers=0.
//   Data memory is not reset.
//  FSM states:
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command.
//    LDI/MOVE/STORE go to RESP. LOAD goes to MRD.
//   MRD: memory read data is available. Write it to rdst1, load it into rsp_r1, go to RESP.
//   RESP: rsp_valid=1; outputs held stable. On rsp_ready, go to IDLE.
//  Latency from accept to rsp_valid: 1 cycle for LDI/MOVE/STORE, 2 cycles for LOAD.
//  Minimum issue interval is 2 cycles (3 for LOAD). rsp_ready held high is assumed by that figure.
//  Register-file writes happen on the accept edge; the LOAD write happens on the MRD edge.
//  LDI: reg[rdst1]=imm1 and reg[rdst2]=imm2. If rdst1==rdst2, imm2 wins.
//   rsp_r1/rsp_r2 = post-write values of reg[rsrc1]/reg[rsrc2] (write-first).
//   Example: LDI rdst1=3 imm1=0x11, rsrc1=3 -> rsp_r1=0x11.
//  MOVE: reg[rdst1] = reg[rsrc1]; rsp_r1 = moved value. rsrc1==rdst1 leaves the register unchanged.
//  STORE: mem[addr] = reg[rsrc1] on the accept edge; rsp_r1 = stored value.
//  STORE then LOAD to the same address: the LOAD returns the new value.
//   No bypass is needed because the commands are serialised.
//  Addresses wrap naturally; no out-of-range case exists since NREG and DEPTH are powers of 2.
//  cmd_* is ignored whenever cmd_ready=0. No command is dropped once accepted.
//  Reset asserted mid-operation: FSM returns to IDLE and any pending response is discarded.
//   A LOAD caught in MRD does not write its register.
//   A STORE completed on its accept edge persists in memory.
// CONFIGURATION
//  REGMEM_ZERO_REG_EN defined: register 0 is hardwired to 0.
//   Writes to reg 0 are dropped (LDI, MOVE and LOAD alike) and reads of reg 0 return 0.
//   With LDI rdst1=rdst2=0, both writes are dropped.
//  REGMEM_ZERO_REG_EN undefined: register 0 behaves like any other register.
// STRUCTURE
//  regmem_pkg holds:
//   op encoding constants OP_LDI/OP_MOVE/OP_LOAD/OP_STORE
//   state typedef {IDLE, MRD, RESP}
//   default DW/NREG/DEPTH constants
//  Sub-module regmem_dpram: DEPTH x DW memory; one synchronous write port, one registered read port.
//  The register file stays inline as a reg array with an async-reset loop.
// TESTING
//  1. Reset, then LDI rdst1=1 imm1=0xA5, rdst2=2 imm2=0x3C, rsrc1=1, rsrc2=2
//     -> rsp_valid after 1 cycle; r1=0xA5, r2=0x3C.
//  2. STORE rsrc1=1 addr=7, then LOAD rdst1=4 addr=7
//     -> STORE r1=0xA5; LOAD rsp after 2 cycles, r1=0xA5; then LDI rsrc1=4 returns 0xA5.
//  3. Hold rsp_ready=0 for 5 cycles after a MOVE
//     -> rsp_valid and rsp_r1 stay stable, cmd_ready=0, a new cmd_valid is ignored;
//        on release, cmd_ready returns the next cycle.
//  4. LDI rdst1=rdst2=5 imm1=0x01 imm2=0x02 rsrc1=5 -> r1=0x02.
//  5. Assert rst_n=0 while in MRD for a LOAD to rdst1=6
//     -> all outputs reset, reg 6 reads 0 afterwards, busy=0.
//  6. With REGMEM_ZERO_REG_EN: LDI rdst1=0 imm1=0xFF rsrc1=0 -> r1=0x00.
//     Without it -> r1=0xFF.

Source files
------------

// File: rtl/regmem_pkg.sv
// rtl/regmem_pkg.sv - shared op codes, FSM state type and default sizes for regmem_unit
package regmem_pkg;

  localparam int DW_DEF    = 8;
  localparam int NREG_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  localparam logic [1:0] OP_LDI   = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MRD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/regmem_dpram.sv
// rtl/regmem_dpram.sv - DEPTH x DW data memory, one synchronous write port, one registered read port
module regmem_dpram #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 32,
  localparam int MAW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [MAW-1:0] wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [MAW-1:0] rd_addr,
  output logic [DW-1:0]  rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Memory contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/regmem_unit.sv
// rtl/regmem_unit.sv - clocked register file + data memory command unit (option: REGMEM_ZERO_REG_EN)
module regmem_unit
  import regmem_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int NREG  = NREG_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int RAW   = $clog2(NREG),
  localparam int MAW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [RAW-1:0] cmd_rdst1,
  input  logic [RAW-1:0] cmd_rdst2,
  input  logic [RAW-1:0] cmd_rsrc1,
  input  logic [RAW-1:0] cmd_rsrc2,
  input  logic [DW-1:0]  cmd_imm1,
  input  logic [DW-1:0]  cmd_imm2,
  input  logic [MAW-1:0] cmd_addr,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_r1,
  output logic [DW-1:0]  rsp_r2,
  output logic           busy
);

`ifdef REGMEM_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_t         state, state_nxt;
  logic           accept;
  logic [RAW-1:0] ld_rdst;
  logic [DW-1:0]  regs [NREG];
  logic [DW-1:0]  src1_val, src2_val;
  logic [DW-1:0]  ldi_r1, ldi_r2;
  logic           wa_en, wb_en;
  logic [RAW-1:0] wa_addr;
  logic [DW-1:0]  wa_data;
  logic [DW-1:0]  mem_rdata;
  logic           ok1, ok2;

  assign accept = cmd_valid && cmd_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = (cmd_op == OP_LOAD) ? MRD : RESP;
      end
      MRD: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register reads; reg 0 reads as zero when hardwired.
  always_comb begin
    src1_val = regs[cmd_rsrc1];
    src2_val = regs[cmd_rsrc2];
    if (ZERO_REG && cmd_rsrc1 == '0) src1_val = '0;
    if (ZERO_REG && cmd_rsrc2 == '0) src2_val = '0;
  end

  // LDI readback is write-first: rdst2 takes priority over rdst1, dropped writes fall through.
  always_comb begin
    ok1 = !(ZERO_REG && cmd_rdst1 == '0);
    ok2 = !(ZERO_REG && cmd_rdst2 == '0);
    ldi_r1 = src1_val;
    ldi_r2 = src2_val;
    if (ok1 && cmd_rsrc1 == cmd_rdst1) ldi_r1 = cmd_imm1;
    if (ok2 && cmd_rsrc1 == cmd_rdst2) ldi_r1 = cmd_imm2;
    if (ok1 && cmd_rsrc2 == cmd_rdst1) ldi_r2 = cmd_imm1;
    if (ok2 && cmd_rsrc2 == cmd_rdst2) ldi_r2 = cmd_imm2;
  end

  // Write-port selection: LDI/MOVE on the accept edge, LOAD on the MRD edge.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = cmd_rdst1;
    wa_data = cmd_imm1;
    if (state == MRD) begin
      wa_en   = 1'b1;
      wa_addr = ld_rdst;
      wa_data = mem_rdata;
    end else if (accept && cmd_op == OP_LDI) begin
      wa_en = 1'b1;
    end else if (accept && cmd_op == OP_MOVE) begin
      wa_en   = 1'b1;
      wa_data = src1_val;
    end
    if (ZERO_REG && wa_addr == '0) wa_en = 1'b0;
    wb_en = accept && cmd_op == OP_LDI && ok2;
  end

  // Register file; the second port is written last so imm2 wins on rdst1==rdst2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wa_en) regs[wa_addr]   <= wa_data;
      if (wb_en) regs[cmd_rdst2] <= cmd_imm2;
    end
  end

  // Response data and the LOAD destination captured for the MRD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_r1  <= '0;
      rsp_r2  <= '0;
      ld_rdst <= '0;
    end else if (accept) begin
      ld_rdst <= cmd_rdst1;
      rsp_r2  <= '0;
      case (cmd_op)
        OP_LDI: begin
          rsp_r1 <= ldi_r1;
          rsp_r2 <= ldi_r2;
        end
        OP_LOAD: rsp_r1 <= rsp_r1;
        default: rsp_r1 <= src1_val;
      endcase
    end else if (state == MRD) begin
      rsp_r1 <= mem_rdata;
    end
  end

  regmem_dpram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_dpram (
    .clk     (clk),
    .wr_en   (accept && cmd_op == OP_STORE),
    .wr_addr (cmd_addr),
    .wr_data (src1_val),
    .rd_en   (accept && cmd_op == OP_LOAD),
    .rd_addr (cmd_addr),
    .rd_data (mem_rdata)
  );

endmodule

// File: tb/tb_regmem_unit.sv
// tb/tb_regmem_unit.sv - self-checking bench for regmem_unit against a behavioural model
module tb_regmem_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_rdst1, cmd_rdst2, cmd_rsrc1, cmd_rsrc2, cmd_addr;
  logic [7:0] cmd_imm1, cmd_imm2;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_r1, rsp_r2;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_reg [32];
  logic [7:0] m_mem [32];
  bit         m_vld [32];

  regmem_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rdst1 (cmd_rdst1),
    .cmd_rdst2 (cmd_rdst2),
    .cmd_rsrc1 (cmd_rsrc1),
    .cmd_rsrc2 (cmd_rsrc2),
    .cmd_imm1  (cmd_imm1),
    .cmd_imm2  (cmd_imm2),
    .cmd_addr  (cmd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r1    (rsp_r1),
    .rsp_r2    (rsp_r2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input int r);
`ifdef REGMEM_ZERO_REG_EN
    if (r == 0) return 8'h00;
`endif
    return m_reg[r];
  endfunction

  task automatic m_wr(input int r, input logic [7:0] v);
`ifdef REGMEM_ZERO_REG_EN
    if (r == 0) return;
`endif
    m_reg[r] = v;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
  endtask

  task automatic drive(input logic [1:0] op, input int d1, input int d2, input int s1,
                       input int s2, input logic [7:0] i1, input logic [7:0] i2, input int a);
    logic [4:0] t;
    cmd_op = op;
    t = d1[4:0]; cmd_rdst1 = t;
    t = d2[4:0]; cmd_rdst2 = t;
    t = s1[4:0]; cmd_rsrc1 = t;
    t = s2[4:0]; cmd_rsrc2 = t;
    t = a[4:0];  cmd_addr  = t;
    cmd_imm1 = i1;
    cmd_imm2 = i2;
  endtask

  // Issues one command, updates the model, checks latency, response data and re-readiness.
  task automatic do_cmd(input string tag, input logic [1:0] op, input int d1, input int d2,
                        input int s1, input int s2, input logic [7:0] i1, input logic [7:0] i2,
                        input int a);
    logic [7:0] e1, e2, v;
    int lat, wait_cnt;
    e2 = 8'h00;
    case (op)
      2'b00: begin
        m_wr(d1, i1);
        m_wr(d2, i2);
        e1 = m_rd(s1);
        e2 = m_rd(s2);
      end
      2'b01: begin
        v = m_rd(s1);
        m_wr(d1, v);
        e1 = v;
      end
      2'b10: begin
        e1 = m_mem[a];
        m_wr(d1, e1);
      end
      default: begin
        e1 = m_rd(s1);
        m_mem[a] = e1;
        m_vld[a] = 1'b1;
      end
    endcase
    @(negedge clk);
    drive(op, d1, d2, s1, s2, i1, i2, a);
    cmd_valid = 1'b1;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, (op == 2'b10) ? 2 : 1);
    chk({tag, ".r1"}, rsp_r1, e1);
    chk({tag, ".r2"}, rsp_r2, e2);
    @(negedge clk);
    chk({tag, ".rdy"}, cmd_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    int op, a;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 8'h00, 8'h00, 0);
    m_reset();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 1'b1);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.r1", rsp_r1, 8'h00);
    chk("rst.r2", rsp_r2, 8'h00);
    chk("rst.busy", busy, 1'b0);
    rst_n = 1'b1;

    do_cmd("t1.ldi", 2'b00, 1, 2, 1, 2, 8'hA5, 8'h3C, 0);
    chk("t1.r1_const", rsp_r1, 8'hA5);

    do_cmd("t2.store", 2'b11, 0, 0, 1, 0, 8'h00, 8'h00, 7);
    do_cmd("t2.load", 2'b10, 4, 0, 0, 0, 8'h00, 8'h00, 7);
    do_cmd("t2.readback", 2'b00, 10, 11, 4, 1, 8'h12, 8'h34, 0);

    // Back-pressure: response must hold while rsp_ready is low and new commands are ignored.
    rsp_ready = 1'b0;
    @(negedge clk);
    drive(2'b01, 8, 0, 2, 0, 8'h00, 8'h00, 0);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_wr(8, m_rd(2));
    held = m_rd(2);
    drive(2'b00, 9, 9, 9, 9, 8'h77, 8'h77, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3.rsp_valid", rsp_valid, 1'b1);
      chk("t3.r1", rsp_r1, held);
      chk("t3.cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3.release", cmd_ready, 1'b1);
    do_cmd("t3.reg9", 2'b00, 12, 13, 9, 8, 8'h01, 8'h02, 0);

    do_cmd("t4.same_dst", 2'b00, 5, 5, 5, 5, 8'h01, 8'h02, 0);
    chk("t4.const", rsp_r1, 8'h02);

    // Reset while the LOAD is in its memory-read cycle.
    @(negedge clk);
    drive(2'b10, 6, 0, 0, 0, 8'h00, 8'h00, 7);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t5.in_mrd_busy", busy, 1'b1);
    chk("t5.in_mrd_valid", rsp_valid, 1'b0);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("t5.cmd_ready", cmd_ready, 1'b1);
    chk("t5.rsp_valid", rsp_valid, 1'b0);
    chk("t5.r1", rsp_r1, 8'h00);
    chk("t5.r2", rsp_r2, 8'h00);
    chk("t5.busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("t5.reg6", 2'b00, 1, 2, 6, 4, 8'h00, 8'h00, 0);
    do_cmd("t5.mem_kept", 2'b10, 3, 0, 0, 0, 8'h00, 8'h00, 7);

    do_cmd("t6.zero", 2'b00, 0, 20, 0, 20, 8'hFF, 8'h66, 0);
`ifdef REGMEM_ZERO_REG_EN
    chk("t6.const", rsp_r1, 8'h00);
`else
    chk("t6.const", rsp_r1, 8'hFF);
`endif

    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 31));
      if (op == 2) begin
        a = -1;
        for (int k = 0; k < 32; k++) if (m_vld[k] && a < 0) a = k;
        if (a < 0) op = 3;
        else begin
          a = int'($urandom_range(0, 31));
          while (!m_vld[a]) a = (a + 1) % 32;
        end
      end
      do_cmd($sformatf("rnd%0d", n), 2'(op), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
